// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter: port ids and the
// registered command word that sits between arbitration and the memory.
package dmem_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {
    PORT_CORE   = 1'b0,
    PORT_LOADER = 1'b1
  } port_e;

  typedef struct packed {
    logic              valid;
    port_e             port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              oor;
  } cmd_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational from the requests
// and the registered 'last' winner; no grants are issued while in reset.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_e last_q, last_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    gnt_o = 2'b00;
    if (rst_n) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == PORT_CORE) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[1])      last_d = PORT_LOADER;
    else if (gnt_o[0]) last_d = PORT_CORE;
  end

  // Port 0 must win the first contention after reset, hence 'last' = loader.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= PORT_LOADER;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core (port 0) and the loader
// (port 1): round-robin accept, one registered command stage, one response stage.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH  = dmem_pkg::DEPTH,
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rsp_valid,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_err,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] gnt;
  cmd_t       cmd_q, cmd_d;

  logic              rsp_valid_q, rsp_valid_d;
  port_e             rsp_port_q,  rsp_port_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({p1_req, p0_req}),
    .gnt_o (gnt)
  );

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  always_comb begin
    cmd_d = '0;
    if (gnt[1]) begin
      cmd_d.valid = 1'b1;
      cmd_d.port  = PORT_LOADER;
      cmd_d.we    = p1_we;
      cmd_d.addr  = p1_addr;
      cmd_d.wdata = p1_wdata;
    end else if (gnt[0]) begin
      cmd_d.valid = 1'b1;
      cmd_d.port  = PORT_CORE;
      cmd_d.we    = p0_we;
      cmd_d.addr  = p0_addr;
      cmd_d.wdata = p0_wdata;
    end
    cmd_d.oor = cmd_d.valid && ({1'b0, cmd_d.addr} >= (ADDR_W+1)'(DEPTH));
  end

  // Strobes are gated by rst_n so a command caught by reset never touches memory.
  assign mem_read  = cmd_q.valid & ~cmd_q.we & ~cmd_q.oor & rst_n;
  assign mem_write = cmd_q.valid &  cmd_q.we & ~cmd_q.oor & rst_n;
  assign mem_addr  = cmd_q.valid ? cmd_q.addr  : '0;
  assign mem_wdata = cmd_q.valid ? cmd_q.wdata : '0;

  always_comb begin
    rsp_valid_d = cmd_q.valid;
    rsp_port_d  = cmd_q.port;
    rsp_err_d   = cmd_q.valid & cmd_q.oor;
    rsp_rdata_d = (cmd_q.valid && !cmd_q.we && !cmd_q.oor) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_CORE;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Only the addressed port sees the response; the other port reads zero.
  always_comb begin
    p0_rsp_valid = rsp_valid_q & (rsp_port_q == PORT_CORE);
    p1_rsp_valid = rsp_valid_q & (rsp_port_q == PORT_LOADER);
    p0_err       = p0_rsp_valid & rsp_err_q;
    p1_err       = p1_rsp_valid & rsp_err_q;
    p0_rdata     = p0_rsp_valid ? rsp_rdata_q : '0;
    p1_rdata     = p1_rsp_valid ? rsp_rdata_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle stimulus table with hand-computed
// grants and memory strobes, plus a scoreboard monitor for the responses.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p1_gnt, p0_rsp_valid, p1_rsp_valid, p0_err, p1_err;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  typedef struct {
    logic       r0, w0; logic [7:0] a0, d0;
    logic       r1, w1; logic [7:0] a1, d1;
    logic       g0, g1;
    logic [7:0] erd;  logic eerr;
    logic       emr, emw; logic [7:0] ema;
  } row_t;

  row_t rows[13];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req       (p0_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p0_gnt       (p0_gnt),
    .p1_gnt       (p1_gnt),
    .p0_rsp_valid (p0_rsp_valid),
    .p1_rsp_valid (p1_rsp_valid),
    .p0_rdata     (p0_rdata),
    .p1_rdata     (p1_rdata),
    .p0_err       (p0_err),
    .p1_err       (p1_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural single-port memory: combinational read, write at the edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [7:0] a0, d0,
                       input logic r1, w1, input logic [7:0] a1, d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  // Response monitor: pops the expected entry whenever a port presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (p0_rsp_valid) begin
      if (q0.size() == 0) begin
        tests++; errors++;
        $display("FAIL p0_rsp_unexpected: got rsp_valid=1 expected none at %0t", $time);
      end else begin
        e = q0.pop_front();
        check("p0_rdata", 32'(p0_rdata), 32'(e.rdata));
        check("p0_err",   32'(p0_err),   32'(e.err));
      end
    end else begin
      check("p0_idle_zero", 32'({p0_err, p0_rdata}), 32'd0);
    end
    if (p1_rsp_valid) begin
      if (q1.size() == 0) begin
        tests++; errors++;
        $display("FAIL p1_rsp_unexpected: got rsp_valid=1 expected none at %0t", $time);
      end else begin
        e = q1.pop_front();
        check("p1_rdata", 32'(p1_rdata), 32'(e.rdata));
        check("p1_err",   32'(p1_err),   32'(e.err));
      end
    end else begin
      check("p1_idle_zero", 32'({p1_err, p1_rdata}), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    //            r0 w0 a0     d0     r1 w1 a1     d1     g0 g1 erd    eerr mr mw ma
    rows[0]  = '{1, 1, 8'd3,  8'hA5, 0, 0, 8'd0,  8'h00, 1, 0, 8'h00, 0,   0, 0, 8'd0};
    rows[1]  = '{0, 0, 8'd0,  8'h00, 1, 0, 8'd3,  8'h00, 0, 1, 8'hA5, 0,   0, 1, 8'd3};
    rows[2]  = '{1, 0, 8'd3,  8'h00, 1, 1, 8'd7,  8'h3C, 1, 0, 8'hA5, 0,   1, 0, 8'd3};
    rows[3]  = '{1, 0, 8'd7,  8'h00, 1, 1, 8'd7,  8'h3C, 0, 1, 8'h00, 0,   1, 0, 8'd3};
    rows[4]  = '{1, 0, 8'd7,  8'h00, 1, 0, 8'd3,  8'h00, 1, 0, 8'h3C, 0,   0, 1, 8'd7};
    rows[5]  = '{1, 1, 8'd15, 8'h5A, 1, 0, 8'd3,  8'h00, 0, 1, 8'hA5, 0,   1, 0, 8'd7};
    rows[6]  = '{1, 1, 8'd15, 8'h5A, 1, 0, 8'd15, 8'h00, 1, 0, 8'h00, 0,   1, 0, 8'd3};
    rows[7]  = '{0, 0, 8'd0,  8'h00, 1, 0, 8'd15, 8'h00, 0, 1, 8'h5A, 0,   0, 1, 8'd15};
    rows[8]  = '{1, 0, 8'd16, 8'h00, 0, 0, 8'd0,  8'h00, 1, 0, 8'h00, 1,   1, 0, 8'd15};
    rows[9]  = '{1, 0, 8'd15, 8'h00, 0, 0, 8'd0,  8'h00, 1, 0, 8'h5A, 0,   0, 0, 8'd16};
    rows[10] = '{0, 0, 8'd0,  8'h00, 1, 1, 8'hFF, 8'h77, 0, 1, 8'h00, 1,   1, 0, 8'd15};
    rows[11] = '{0, 0, 8'd0,  8'h00, 0, 0, 8'd0,  8'h00, 0, 0, 8'h00, 0,   0, 0, 8'hFF};
    rows[12] = '{0, 0, 8'd0,  8'h00, 0, 0, 8'd0,  8'h00, 0, 0, 8'h00, 0,   0, 0, 8'd0};

    // Reset with p0 requesting: no grant may appear while rst_n is low.
    rst_n = 1'b0;
    drive(1, 1, 8'd9, 8'h11, 1, 0, 8'd2, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_no_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
    check("rst_no_mem", 32'({mem_read, mem_write}), 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);
    @(negedge clk);
    check("post_rst_outputs", 32'({p0_gnt, p1_gnt, p0_rsp_valid, p1_rsp_valid,
                                   mem_read, mem_write, mem_addr, mem_wdata}), 32'd0);

    foreach (rows[i]) begin
      @(posedge clk); #1;
      drive(rows[i].r0, rows[i].w0, rows[i].a0, rows[i].d0,
            rows[i].r1, rows[i].w1, rows[i].a1, rows[i].d1);
      @(negedge clk);
      check($sformatf("row%0d_gnt", i), 32'({p1_gnt, p0_gnt}), 32'({rows[i].g1, rows[i].g0}));
      check($sformatf("row%0d_mem_rw", i), 32'({mem_read, mem_write}),
            32'({rows[i].emr, rows[i].emw}));
      check($sformatf("row%0d_mem_addr", i), 32'(mem_addr), 32'(rows[i].ema));
      if (i == 1) check("row1_mem_wdata", 32'(mem_wdata), 32'h00A5);
      if (rows[i].g0) q0.push_back('{rows[i].erd, rows[i].eerr});
      if (rows[i].g1) q1.push_back('{rows[i].erd, rows[i].eerr});
    end

    // Write to addr 5 caught in the command stage by reset: must be dropped.
    @(posedge clk); #1;
    drive(1, 1, 8'd5, 8'h99, 0, 0, 8'd0, 8'h00);
    @(negedge clk);
    check("drop_wr_gnt", 32'(p0_gnt), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);
    @(negedge clk);
    check("drop_wr_mem_write", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 0, 8'd5, 8'h00, 1, 0, 8'd3, 8'h00);
    @(negedge clk);
    check("post_rst_contention", 32'({p1_gnt, p0_gnt}), 32'b01);
    check("addr5_unchanged", 32'(mem[5]), 32'd0);
    q0.push_back('{8'h00, 1'b0});
    @(posedge clk); #1;
    drive(0, 0, 8'd0, 8'h00, 1, 0, 8'd3, 8'h00);
    @(negedge clk);
    check("loser_granted_next", 32'({p1_gnt, p0_gnt}), 32'b10);
    q1.push_back('{8'hA5, 1'b0});
    @(posedge clk); #1;
    drive(0, 0, 8'd0, 8'h00, 0, 0, 8'd0, 8'h00);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("addr5_final", 32'(mem[5]), 32'd0);
    check("addr7_final", 32'(mem[7]), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the data memory. Shares the single-port data memory between the core load/store unit (port 0) and the program loader / debug port (port 1). Uses round-robin arbitration, a registered command stage and a registered response stage. Out-of-range accesses return an error instead of reaching the memory.

## Interface

Parameters:
- `DEPTH`, 16: number of implemented memory bytes; addresses ≥ DEPTH are out of range.
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `p0_req`, `p1_req`  in  1  request valid, held until granted.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read; qualified by req.
- `p0_addr`, `p1_addr`  in  ADDR_W  byte address.
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data.
- `p0_gnt`, `p1_gnt`  out  1  request accepted this cycle; combinational from req and arbitration state.
- `p0_rsp_valid`, `p1_rsp_valid`  out  1  one-cycle response pulse, issued for reads and writes.
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data, valid with rsp_valid; 0 for writes and errors.
- `p0_err`, `p1_err`  out  1  out-of-range access, valid with rsp_valid.
- `mem_read`  out  1  to memory read enable.
- `mem_write`  out  1  to memory write enable.
- `mem_addr`  out  ADDR_W  to memory address.
- `mem_wdata`  out  DATA_W  to memory write data.
- `mem_rdata`  in  DATA_W  from memory; combinational read data.

## Operation

- At most one grant per cycle; `gnt` is asserted only together with `req`.
- A transfer completes when `req` and `gnt` are both high at a rising edge.
- Arbitration is round-robin with a 1-bit `last` pointer.
  - Single requester: it is always granted.
  - Both requesting: the port not equal to `last` wins.
  - `last` updates to the winner on every accepted transfer.
  - Reset value of `last` is 1, so port 0 wins the first contention.
- Command stage registers: `cmd_valid`, `cmd_port`, `cmd_we`, `cmd_addr`, `cmd_wdata`, `cmd_oor`.
  - Loaded from the winner on accept; `cmd_valid` is cleared otherwise.
  - `cmd_oor` = (addr ≥ DEPTH).
- Memory drive, all outputs combinational from the command stage:
  - `mem_read` = cmd_valid & !cmd_we & !cmd_oor & rst_n.
  - `mem_write` = cmd_valid & cmd_we & !cmd_oor & rst_n.
  - `mem_addr` = cmd_addr and `mem_wdata` = cmd_wdata when cmd_valid, else 0.
- Response stage: on the edge ending the command cycle, the arbiter registers rsp_valid, port, err and rdata.
  - rdata = mem_rdata for an in-range read, else 0.
  - Only the addressed port's `rsp_valid`, `rdata` and `err` are driven; the other port's outputs read 0.
- No backpressure: a new request can be accepted every cycle (full throughput, one command in flight per stage).
- Out-of-range accesses never assert `mem_read` or `mem_write`.

## Timing

- Cycle N: req & gnt. Cycle N+1: memory access; a write commits at the N+1→N+2 edge. Cycle N+2: rsp_valid for one cycle.
- Read-after-write to the same address in back-to-back accepted cycles returns the new data, because the write commits before the read's memory cycle.
- Simultaneous requests: one winner, as defined under Operation; the loser holds `req` and is granted next cycle if no other contention rule overrides.
- Reset (rst_n low at an edge):
  - Clears cmd/rsp stages and sets `last` = 1.
  - All outputs are 0 in the cycle after reset.
  - No grants are issued while rst_n is low.
  - In-flight commands are dropped and get no response.
  - `mem_read` and `mem_write` are forced to 0 in any cycle with rst_n low.
- addr = DEPTH−1 is in range; addr = DEPTH and addr = 8'hFF are out of range.

## Structure

- Shared package `dmem_pkg`: DEPTH, ADDR_W and DATA_W constants; the port-id type (`PORT_CORE`=0, `PORT_LOADER`=1); the command struct (valid, port, we, addr, wdata, oor).
- Sub-module `rr_arb2`: 2-requester round-robin grant logic plus the `last` register. Everything else lives in `dmem_arbiter`.

## Test plan

- Reset then p0 writes 8'hA5 to addr 3:
  - p0_gnt is high in the same cycle.
  - mem_write is high with addr 3 one cycle later.
  - p0_rsp_valid is high with err=0 two cycles after accept.
- p1 reads addr 3 on the cycle right after the write above: p1_rdata=8'hA5 at N+2.
- Both ports request continuously from reset: grants alternate p0, p1, p0, p1, with one accept per cycle.
- p0 reads addr 16 with DEPTH=16:
  - mem_read and mem_write stay 0.
  - p0_rsp_valid=1, p0_err=1, p0_rdata=0.
  - A read at addr 15 returns err=0.
- rst_n deasserted while a write to addr 5 is in the command stage:
  - mem_write stays 0 and addr 5 is unchanged.
  - No rsp_valid appears.
  - After release, the first contention goes to p0.
